fetch_queue: RTL and testbench

//   Parametrised prefetching instruction-fetch unit; next generation of the single-request fetch stage in core.

---
 rtl/fetch_queue.sv | 158 +++++++++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch unit: pipelined reads into an in-order instruction FIFO, stale responses dropped after redirect.
// Optional build macro FETCH_PERF_EN adds perf_fetched_o / perf_flushed_o event counters.
module fetch_queue #(
    parameter int unsigned     Xlen           = 32,
    parameter int unsigned     Ilen           = 32,
    parameter int unsigned     Depth          = 4,
    parameter int unsigned     MaxOutstanding = 2,
    parameter logic [Xlen-1:0] ResetPc        = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            control_hazard_i,
    input  logic [Xlen-1:0] pc_target_i,
    input  logic            mem_ready_i,
    output logic            mem_valid_o,
    output logic [Xlen-1:0] mem_addr_o,
    input  logic [Ilen-1:0] mem_rdata_i,
    input  logic            mem_rvalid_i,
    input  logic            inst_ready_i,
    output logic [Xlen-1:0] inst_pc_o,
    output logic [Ilen-1:0] inst_data_o,
    output logic            inst_valid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [Xlen-1:0] perf_fetched_o,
    output logic [Xlen-1:0] perf_flushed_o
`endif
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned SumW = CntW + 1;

    typedef struct packed {
        logic [Xlen-1:0] pc;
        logic [Ilen-1:0] data;
    } entry_t;

    entry_t          fifo_q [Depth];
    logic [PtrW-1:0] wr_ptr, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr, rd_ptr_d;
    logic [CntW-1:0] count, count_d;
    logic [CntW-1:0] outstanding, outstanding_d;
    logic [CntW-1:0] discard, discard_d;
    logic [Xlen-1:0] fetch_pc, fetch_pc_d;
    logic [Xlen-1:0] resp_pc, resp_pc_d;
    logic            inst_valid_q;

    logic            issue_ok;
    logic            accept;
    logic            push;
    logic            pop;
    logic            drop;
    logic [Xlen-1:0] target_pc;

    // Credit check: every accepted read must have a guaranteed FIFO slot.
    assign issue_ok  = (outstanding < CntW'(MaxOutstanding)) &&
                       ((SumW'(outstanding) + SumW'(count)) < SumW'(Depth));
    assign mem_valid_o = !rst_i && !control_hazard_i && issue_ok;
    assign mem_addr_o  = fetch_pc;
    assign accept      = mem_valid_o && mem_ready_i;

    assign push        = mem_rvalid_i && !control_hazard_i && (discard == '0);
    assign drop        = mem_rvalid_i && (control_hazard_i || (discard != '0));
    assign pop         = inst_valid_q && inst_ready_i && !control_hazard_i;
    assign target_pc   = pc_target_i & ~Xlen'(3);

    assign inst_valid_o = inst_valid_q;
    assign inst_pc_o    = fifo_q[rd_ptr].pc;
    assign inst_data_o  = fifo_q[rd_ptr].data;

    // Next-state for pointers, occupancy, credits and PCs.
    always_comb begin
        wr_ptr_d      = wr_ptr;
        rd_ptr_d      = rd_ptr;
        count_d       = count;
        discard_d     = discard;
        fetch_pc_d    = fetch_pc;
        resp_pc_d     = resp_pc;
        outstanding_d = outstanding + CntW'(accept) - CntW'(mem_rvalid_i);

        if (control_hazard_i) begin
            // Everything still in flight belongs to the old path.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            discard_d  = outstanding_d;
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr + PtrW'(1);
                resp_pc_d = resp_pc + Xlen'(4);
            end
            if (drop) begin
                discard_d = discard - CntW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr + PtrW'(1);
            end
            count_d = count + CntW'(push) - CntW'(pop);
            if (accept) begin
                fetch_pc_d = fetch_pc + Xlen'(4);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            outstanding  <= '0;
            discard      <= '0;
            fetch_pc     <= ResetPc;
            resp_pc      <= ResetPc;
            inst_valid_q <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_d;
            rd_ptr       <= rd_ptr_d;
            count        <= count_d;
            outstanding  <= outstanding_d;
            discard      <= discard_d;
            fetch_pc     <= fetch_pc_d;
            resp_pc      <= resp_pc_d;
            inst_valid_q <= (count_d != '0);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            fifo_q[wr_ptr] <= '{pc: resp_pc, data: mem_rdata_i};
        end
    end

`ifdef FETCH_PERF_EN
    logic [Xlen-1:0] perf_fetched_q;
    logic [Xlen-1:0] perf_flushed_q;
    logic [Xlen-1:0] flush_amt;

    assign flush_amt = (control_hazard_i ? Xlen'(count) : '0) + Xlen'(drop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + Xlen'(pop);
            perf_flushed_q <= perf_flushed_q + flush_amt;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_flushed_o = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised self-checking bench for fetch_queue against a queue-based reference model and an in-order memory model.
module tb_fetch_queue;

    localparam int unsigned Xlen   = 32;
    localparam int unsigned Ilen   = 32;
    localparam int unsigned Depth  = 4;
    localparam int unsigned MaxOut = 2;
    localparam logic [31:0] RPc    = 32'h100;

    logic        clk = 1'b0;
    logic        rst, hz, mem_ready, mem_valid, mem_rvalid, inst_ready, inst_valid;
    logic [31:0] tgt, mem_addr, mem_rdata, inst_pc, inst_data;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .Xlen(Xlen), .Ilen(Ilen), .Depth(Depth), .MaxOutstanding(MaxOut), .ResetPc(RPc)
    ) dut (
        .clk_i(clk), .rst_i(rst), .control_hazard_i(hz), .pc_target_i(tgt),
        .mem_ready_i(mem_ready), .mem_valid_o(mem_valid), .mem_addr_o(mem_addr),
        .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .inst_ready_i(inst_ready),
        .inst_pc_o(inst_pc), .inst_data_o(inst_data), .inst_valid_o(inst_valid)
`ifdef FETCH_PERF_EN
        , .perf_fetched_o(perf_fetched), .perf_flushed_o(perf_flushed)
`endif
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    ent_t        fifo_m[$];
    ent_t        delivered[$];
    req_t        memq[$];
    int          m_out, m_disc, cyc, last_due, dmin, dmax;
    logic [31:0] m_fetch, m_resp;
    bit          m_init;
    int          n_tests, n_fail;
`ifdef FETCH_PERF_EN
    logic [31:0] m_fetched, m_flushed;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, check just after, advance the model at posedge.
    task automatic step(input bit r, input bit h, input logic [31:0] t, input bit rdy, input bit ir);
        bit   rv, exp_mv, was_disc;
        logic [31:0] rd;
        int   due;
        @(negedge clk);
        rv = 1'b0;
        rd = $urandom;
        if (!r && memq.size() > 0 && memq[0].due <= cyc) begin
            rv = 1'b1;
            rd = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end
        rst = r; hz = h; tgt = t; mem_ready = rdy; inst_ready = ir;
        mem_rvalid = rv; mem_rdata = rd;
        #1;
        exp_mv = !r && !h && (m_out < MaxOut) && (m_out + fifo_m.size() < Depth);
        if (m_init) begin
            check("mem_valid", 32'(mem_valid), 32'(exp_mv));
            check("mem_addr", mem_addr, m_fetch);
            check("inst_valid", 32'(inst_valid), 32'(fifo_m.size() != 0));
            if (fifo_m.size() != 0) begin
                check("inst_pc", inst_pc, fifo_m[0].pc);
                check("inst_data", inst_data, fifo_m[0].data);
            end
`ifdef FETCH_PERF_EN
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_flushed", perf_flushed, m_flushed);
`endif
        end
        if (mem_valid && rdy) begin
            due = cyc + int'($urandom_range(dmax, dmin));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: mem_addr, due: due});
        end
        if (m_init && !r) check("outstanding_limit", 32'(memq.size() <= MaxOut), 32'd1);
        if (inst_valid && ir && !h && !r) delivered.push_back('{pc: inst_pc, data: inst_data});
        @(posedge clk);
        if (r) begin
            fifo_m.delete(); memq.delete();
            m_out = 0; m_disc = 0; m_fetch = RPc; m_resp = RPc; m_init = 1'b1; last_due = 0;
`ifdef FETCH_PERF_EN
            m_fetched = '0; m_flushed = '0;
`endif
        end else if (h) begin
`ifdef FETCH_PERF_EN
            m_flushed += 32'(fifo_m.size()) + 32'(rv);
`endif
            fifo_m.delete();
            m_out   = m_out - int'(rv);
            m_disc  = m_out;
            m_fetch = t & ~32'h3;
            m_resp  = m_fetch;
        end else begin
            was_disc = (m_disc > 0);
            if (fifo_m.size() != 0 && ir) begin
                void'(fifo_m.pop_front());
`ifdef FETCH_PERF_EN
                m_fetched++;
`endif
            end
            if (rv) begin
                if (was_disc) begin
                    m_disc--;
`ifdef FETCH_PERF_EN
                    m_flushed++;
`endif
                end else begin
                    fifo_m.push_back('{pc: m_resp, data: mem_word(m_resp)});
                    m_resp += 32'd4;
                end
                m_out--;
            end
            if (exp_mv && rdy) begin
                m_fetch += 32'd4;
                m_out++;
            end
        end
        cyc++;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; last_due = 0; m_init = 1'b0;
        m_out = 0; m_disc = 0; m_fetch = '0; m_resp = '0;
        dmin = 1; dmax = 1;
        rst = 1'b1; hz = 1'b0; tgt = '0; mem_ready = 1'b0; inst_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state pinned with literals.
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        #1;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h100);

        // Streaming with ready memory and 1-cycle responses: one instruction per cycle from cycle 2.
        delivered.delete();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);
        check("stream_count", 32'(delivered.size()), 32'd10);
        if (delivered.size() >= 3) begin
            check("stream_pc0", delivered[0].pc, 32'h100);
            check("stream_pc1", delivered[1].pc, 32'h104);
            check("stream_pc2", delivered[2].pc, 32'h108);
            check("stream_data0", delivered[0].data, mem_word(32'h100));
        end

        // Consumer stall fills the FIFO and stops issue; release delivers in order.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
        #1;
        check("stall_mem_valid", 32'(mem_valid), 32'd0);
        check("stall_inst_valid", 32'(inst_valid), 32'd1);
        delivered.delete();
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 1);
        if (delivered.size() > 0) check("release_pc0", delivered[0].pc, 32'h128);
        else check("release_count", 32'(delivered.size()), 32'd30);
        for (int i = 1; i < delivered.size(); i++)
            check("release_contig", delivered[i].pc, delivered[i-1].pc + 32'd4);

        // Redirect with two reads in flight: both late responses dropped.
        dmin = 3; dmax = 3;
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        delivered.delete();
        step(0, 1, 32'h43, 1, 1);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 1);
        check("redir_count_nz", 32'(delivered.size() != 0), 32'd1);
        if (delivered.size() != 0) begin
            check("redir_pc", delivered[0].pc, 32'h40);
            check("redir_data", delivered[0].data, mem_word(32'h40));
        end

        // Back-to-back redirects: the later target wins.
        dmin = 1; dmax = 1;
        step(0, 0, 0, 1, 1);
        delivered.delete();
        step(0, 1, 32'h80, 1, 1);
        step(0, 1, 32'hC0, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);
        check("b2b_count_nz", 32'(delivered.size() != 0), 32'd1);
        if (delivered.size() != 0) check("b2b_pc", delivered[0].pc, 32'hC0);

        // Random traffic: ready toggling, 1-3 cycle responses, occasional redirects and resets.
        dmin = 1; dmax = 3;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(399) == 0), ($urandom_range(19) == 0), $urandom,
                 $urandom_range(1), ($urandom_range(3) != 0));
        end
        // Drain and confirm quiescence against the model.
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
